// File: rtl/conv_window_sequencer_pkg.sv
// Shared constants and encodings for the CNN co-processor window sequencer.
package cnn_pkg;

  localparam int N      = 8;
  localparam int IMG    = 28;
  localparam int FIL    = 3;
  localparam int OUTW   = IMG - FIL + 1;
  localparam int DEST_W = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_FIL = 3'd1,
    RUN       = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_PASS      = 2'b00,
    OP_CONV      = 2'b01,
    OP_CONV_RELU = 2'b10,
    OP_RSVD      = 2'b11
  } op_e;

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Control/memory-side bundle of the window sequencer; slave is the sequencer itself.
interface conv_window_sequencer_if #(
  parameter int M_AW = 10,
  parameter int F_AW = 3
);
  import cnn_pkg::*;

  logic                start;
  logic [F_AW-1:0]     fil_sel;
  logic [1:0]          op;
  logic                stall;
  logic [M_AW-1:0]     img_addr;
  logic                img_rd_en;
  logic [F_AW-1:0]     fil_addr;
  logic                fil_rd_en;
  logic                W_en;
  logic [1:0]          R_out;
  logic [DEST_W-1:0]   dest;
  logic                busy;
  logic                done;

  modport master (
    output start, fil_sel, op, stall,
    input  img_addr, img_rd_en, fil_addr, fil_rd_en, W_en, R_out, dest, busy, done
  );

  modport slave (
    input  start, fil_sel, op, stall,
    output img_addr, img_rd_en, fil_addr, fil_rd_en, W_en, R_out, dest, busy, done
  );

endinterface

// File: rtl/conv_window_sequencer_window_addr_gen.sv
// Walks the 26x26 window grid, presenting the issued window's top-left address and
// output index as registered outputs while keeping its own pointer to the next window.
module window_addr_gen
  import cnn_pkg::*;
#(
  parameter int M_AW = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              step_i,
  output logic [M_AW-1:0]   img_addr_o,
  output logic [DEST_W-1:0] dest_o,
  output logic              last_o
);

  localparam int CW = $clog2(OUTW);

  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [M_AW-1:0]   curAddr_q, curAddr_d;
  logic [DEST_W-1:0] curDest_q, curDest_d;
  logic [M_AW-1:0]   imgAddr_q, imgAddr_d;
  logic [DEST_W-1:0] destOut_q, destOut_d;

  assign last_o     = (row_q == CW'(OUTW - 1)) && (col_q == CW'(OUTW - 1));
  assign img_addr_o = imgAddr_q;
  assign dest_o     = destOut_q;

  // Row wrap skips the FIL-1 pixels that no window can start on.
  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    curAddr_d = curAddr_q;
    curDest_d = curDest_q;
    imgAddr_d = imgAddr_q;
    destOut_d = destOut_q;
    if (clear_i) begin
      row_d     = '0;
      col_d     = '0;
      curAddr_d = '0;
      curDest_d = '0;
      imgAddr_d = '0;
      destOut_d = '0;
    end else if (step_i) begin
      imgAddr_d = curAddr_q;
      destOut_d = curDest_q;
      curDest_d = curDest_q + DEST_W'(1);
      if (col_q != CW'(OUTW - 1)) begin
        col_d     = col_q + CW'(1);
        curAddr_d = curAddr_q + M_AW'(1);
      end else begin
        col_d     = '0;
        row_d     = row_q + CW'(1);
        curAddr_d = curAddr_q + M_AW'(FIL);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q     <= '0;
      col_q     <= '0;
      curAddr_q <= '0;
      curDest_q <= '0;
      imgAddr_q <= '0;
      destOut_q <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      curAddr_q <= curAddr_d;
      curDest_q <= curDest_d;
      imgAddr_q <= imgAddr_d;
      destOut_q <= destOut_d;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences one 3x3 convolution pass over a 28x28 image: filter fetch, 676 window
// issues, pipeline drain, then a done pulse. Every output is a register.
module conv_window_sequencer
  import cnn_pkg::*;
#(
  parameter int M_AW      = 10,
  parameter int F_AW      = 3,
  parameter int DRAIN_CYC = 3
) (
  input logic                    clock,
  input logic                    reset,
  conv_window_sequencer_if.slave bus
);

  localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e          state_q, state_d;
  logic [F_AW-1:0] filSel_q, filSel_d;
  logic [F_AW-1:0] filAddr_q, filAddr_d;
  op_e             rOut_q, rOut_d;
  logic            filRdEn_q, filRdEn_d;
  logic            imgRdEn_q, imgRdEn_d;
  logic            wEn_q, wEn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DC_W-1:0] drainCnt_q, drainCnt_d;
  logic            genClear, genStep, genLast;

  window_addr_gen #(.M_AW(M_AW)) u_addr_gen (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (genClear),
    .step_i     (genStep),
    .img_addr_o (bus.img_addr),
    .dest_o     (bus.dest),
    .last_o     (genLast)
  );

  assign bus.fil_addr  = filAddr_q;
  assign bus.fil_rd_en = filRdEn_q;
  assign bus.img_rd_en = imgRdEn_q;
  assign bus.W_en      = wEn_q;
  assign bus.R_out     = rOut_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // done_q is visible while already back in IDLE, so a start in that cycle is refused too.
  always_comb begin
    state_d    = state_q;
    filSel_d   = filSel_q;
    filAddr_d  = filAddr_q;
    rOut_d     = rOut_q;
    filRdEn_d  = 1'b0;
    imgRdEn_d  = 1'b0;
    wEn_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drainCnt_d = drainCnt_q;
    genClear   = 1'b0;
    genStep    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          filSel_d = bus.fil_sel;
          rOut_d   = op_e'(bus.op);
          genClear = 1'b1;
          busy_d   = 1'b1;
          state_d  = FETCH_FIL;
        end
      end
      FETCH_FIL: begin
        if (!bus.stall) begin
          filRdEn_d = 1'b1;
          filAddr_d = filSel_q;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          imgRdEn_d = 1'b1;
          wEn_d     = 1'b1;
          genStep   = 1'b1;
          if (genLast) begin
            drainCnt_d = '0;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drainCnt_q == DC_W'(DRAIN_CYC - 1)) begin
          drainCnt_d = '0;
          state_d    = DONE;
        end else begin
          drainCnt_d = drainCnt_q + DC_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      filSel_q   <= '0;
      filAddr_q  <= '0;
      rOut_q     <= OP_PASS;
      filRdEn_q  <= 1'b0;
      imgRdEn_q  <= 1'b0;
      wEn_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      filSel_q   <= filSel_d;
      filAddr_q  <= filAddr_d;
      rOut_q     <= rOut_d;
      filRdEn_q  <= filRdEn_d;
      imgRdEn_q  <= imgRdEn_d;
      wEn_q      <= wEn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drainCnt_q <= drainCnt_d;
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: stimulus queues expected windows and
// filter fetches, a negedge monitor pops and compares whenever the DUT presents one.
module tb_conv_window_sequencer;
  import cnn_pkg::*;

  localparam int M_AW = 10;
  localparam int F_AW = 3;

  typedef struct packed {
    logic [9:0] addr;
    logic [9:0] dest;
    logic [1:0] op;
  } win_t;

  logic clock;
  logic reset;

  conv_window_sequencer_if #(.M_AW(M_AW), .F_AW(F_AW)) bus ();

  conv_window_sequencer #(.M_AW(M_AW), .F_AW(F_AW), .DRAIN_CYC(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  win_t       winQ[$];
  logic [2:0] filQ[$];
  win_t       expWin;
  logic [2:0] expFil;
  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  int         wenCount = 0;
  int         doneCount = 0;
  int         lastWenCycle = 0;
  int         doneCycle = 0;
  logic [9:0] lastAddr = '0;
  logic [9:0] lastDest = '0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait budget expired", name);
  endtask

  function automatic logic [31:0] allOuts();
    return {2'b00, bus.img_addr, bus.img_rd_en, bus.fil_addr, bus.fil_rd_en, bus.W_en,
            bus.R_out, bus.dest, bus.busy, bus.done};
  endfunction

  // Monitor: every presented window / filter fetch must match the head of its queue.
  always @(negedge clock) begin
    cycle = cycle + 1;
    if (reset) begin
      if (bus.W_en) begin
        wenCount++;
        lastWenCycle = cycle;
        lastAddr = bus.img_addr;
        lastDest = bus.dest;
        checkOutput("wen_expected", 32'(winQ.size() != 0), 32'd1);
        if (winQ.size() != 0) begin
          expWin = winQ.pop_front();
          checkOutput($sformatf("window_dest%0d", expWin.dest),
                      {9'd0, bus.img_addr, bus.dest, bus.R_out, bus.img_rd_en},
                      {9'd0, expWin.addr, expWin.dest, expWin.op, 1'b1});
        end
      end
      if (bus.fil_rd_en) begin
        checkOutput("fil_rd_expected", 32'(filQ.size() != 0), 32'd1);
        if (filQ.size() != 0) begin
          expFil = filQ.pop_front();
          checkOutput("fil_addr_sb", 32'(bus.fil_addr), 32'(expFil));
        end
      end
      if (bus.done) begin
        doneCount++;
        doneCycle = cycle;
      end
    end
  end

  task automatic pulseStart(input logic [2:0] f, input logic [1:0] o);
    bus.start   = 1'b1;
    bus.fil_sel = f;
    bus.op      = o;
    @(negedge clock); #1;
    bus.start   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [1:0] o);
    bit seen;
    filQ.push_back(f);
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++)
        winQ.push_back('{addr: 10'(r * 28 + c), dest: 10'(r * 26 + c), op: o});
    wenCount = 0;
    pulseStart(f, o);
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      if (bus.fil_rd_en) begin
        seen = 1;
        break;
      end
    end
    if (!seen) timeoutFail("fil_rd_en_wait");
    checkOutput("fil_addr", 32'(bus.fil_addr), 32'(f));
    @(negedge clock); #1;
    checkOutput("first_window", {11'd0, bus.W_en, bus.fil_rd_en, bus.img_addr, bus.dest},
                {11'd0, 1'b1, 1'b0, 10'd0, 10'd0});
  endtask

  task automatic waitDest(input int d);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock); #1;
      if (bus.W_en && bus.dest == 10'(d)) begin
        seen = 1;
        break;
      end
    end
    if (!seen) timeoutFail($sformatf("wait_dest%0d", d));
  endtask

  task automatic waitDone();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock); #1;
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) timeoutFail("wait_done");
  endtask

  task automatic checkPassEnd(input logic [1:0] o, input int expDones);
    checkOutput("wen_count", 32'(wenCount), 32'd676);
    checkOutput("last_window", {12'd0, lastAddr, lastDest}, {12'd0, 10'd725, 10'd675});
    checkOutput("done_latency", 32'(doneCycle - lastWenCycle), 32'd4);
    checkOutput("done_count", 32'(doneCount), 32'(expDones));
    checkOutput("sb_empty", 32'(winQ.size() + filQ.size()), 32'd0);
    checkOutput("rout_at_done", 32'(bus.R_out), 32'(o));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.fil_sel = '0;
    bus.op      = '0;
    bus.stall   = 1'b0;
    reset       = 1'b1;
    #2 reset    = 1'b0;
    @(negedge clock); #1;
    checkOutput("reset_outputs", allOuts(), 32'd0);
    reset = 1'b1;
    @(negedge clock); #1;

    // Pass 1: filter 5, op conv, with a stall and two ignored starts.
    applyStimulus(3'd5, 2'b01);
    waitDest(99);
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      checkOutput($sformatf("stall_hold%0d", i),
                  {10'd0, bus.W_en, bus.img_rd_en, bus.img_addr, bus.dest},
                  {10'd0, 1'b0, 1'b0, 10'd105, 10'd99});
    end
    bus.stall = 1'b0;
    @(negedge clock); #1;
    checkOutput("resume_dest", {21'd0, bus.W_en, bus.dest}, {21'd0, 1'b1, 10'd100});
    waitDest(300);
    pulseStart(3'd2, 2'b10);
    checkOutput("ignored_start_run", {29'd0, bus.busy, bus.R_out}, {29'd0, 1'b1, 2'b01});
    waitDone();
    checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
    pulseStart(3'd1, 2'b11);
    checkOutput("done_one_cycle", {30'd0, bus.done, bus.busy}, 32'd0);
    repeat (5) @(negedge clock);
    #1;
    checkOutput("idle_after_done", {28'd0, bus.busy, bus.fil_rd_en, bus.R_out}, {28'd0, 1'b0, 1'b0, 2'b01});
    checkPassEnd(2'b01, 1);

    // Pass 2: aborted by reset mid-run.
    applyStimulus(3'd3, 2'b10);
    waitDest(400);
    reset = 1'b0;
    #1;
    checkOutput("async_reset", allOuts(), 32'd0);
    winQ.delete();
    filQ.delete();
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("no_done_on_abort", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_done_count", 32'(doneCount), 32'd1);

    // Pass 3: restart from the origin after the abort.
    applyStimulus(3'd6, 2'b00);
    waitDone();
    repeat (2) @(negedge clock);
    #1;
    checkPassEnd(2'b00, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
